dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a 256-word asynchronous-read data memory.
// Port 0 has priority; port 1 is forced through after MAX_WAIT stalled cycles.
`default_nettype none

module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic                  mem_WE,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic [DATA_WIDTH-1:0] mem_WD,
  input  logic [DATA_WIDTH-1:0] mem_RD
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

  logic                  gnt0, gnt1, force1, bad0, bad1;
  logic [3:0]            wait1_d, wait1_q;
  logic                  rsp0_valid_d, rsp0_valid_q, rsp0_err_d, rsp0_err_q;
  logic                  rsp1_valid_d, rsp1_valid_q, rsp1_err_d, rsp1_err_q;
  logic [DATA_WIDTH-1:0] rsp0_rdata_d, rsp0_rdata_q, rsp1_rdata_d, rsp1_rdata_q;

  always_comb begin
    bad0   = (req0_addr[1:0] != 2'b00) || (req0_addr[ADDR_WIDTH-1:10] != '0);
    bad1   = (req1_addr[1:0] != 2'b00) || (req1_addr[ADDR_WIDTH-1:10] != '0);
    force1 = req1_valid && (wait1_q == c_max_wait);
    gnt0   = !reset && req0_valid && !force1;
    gnt1   = !reset && req1_valid && (!req0_valid || force1);

    // The counter only grows while port 1 is actively being stalled.
    if (!req1_valid || gnt1) begin
      wait1_d = 4'd0;
    end else begin
      wait1_d = wait1_q + 4'd1;
    end

    mem_WE = 1'b0;
    mem_A  = '0;
    mem_WD = '0;
    if (gnt0) begin
      mem_WE = req0_we && !bad0;
      mem_A  = req0_addr;
      mem_WD = req0_wdata;
    end else if (gnt1) begin
      mem_WE = req1_we && !bad1;
      mem_A  = req1_addr;
      mem_WD = req1_wdata;
    end

    rsp0_valid_d = gnt0;
    rsp0_err_d   = gnt0 && bad0;
    rsp0_rdata_d = (gnt0 && !req0_we && !bad0) ? mem_RD : '0;
    rsp1_valid_d = gnt1;
    rsp1_err_d   = gnt1 && bad1;
    rsp1_rdata_d = (gnt1 && !req1_we && !bad1) ? mem_RD : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait1_q      <= 4'd0;
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      wait1_q      <= wait1_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp1_err   = rsp1_err_q;
  assign rsp1_rdata = rsp1_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with queue-based response scoreboard for dmem_arbiter.
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic        mem_WE;
  logic [31:0] mem_A, mem_WD, mem_RD;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] e0_rd, e1_rd;
  logic        e0_err, e1_err;
  logic        a0, a1;
  logic [9:0]  gpat;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    logic [32:0] e;
    if (rsp0_valid) begin
      if (q0.size() == 0) chk("rsp0_unexpected", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rsp0_rdata", rsp0_rdata, e[31:0]);
        chk("rsp0_err", {31'd0, rsp0_err}, {31'd0, e[32]});
      end
    end else chk("rsp0_err_idle", {31'd0, rsp0_err}, 32'd0);
    if (rsp1_valid) begin
      if (q1.size() == 0) chk("rsp1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rsp1_rdata", rsp1_rdata, e[31:0]);
        chk("rsp1_err", {31'd0, rsp1_err}, {31'd0, e[32]});
      end
    end else chk("rsp1_err_idle", {31'd0, rsp1_err}, 32'd0);
  end

  // One clock: check request side at the negedge, push expectations, then advance.
  task automatic step(input bit rst_edge);
    logic        exp_we;
    logic [31:0] exp_a;
    @(negedge clk);
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    chk("two_readies", {31'd0, req0_ready && req1_ready}, 32'd0);
    chk("ready_wo_valid", {30'd0, req0_ready && !req0_valid, req1_ready && !req1_valid}, 32'd0);
    if (reset) chk("ready_in_reset", {30'd0, req0_ready, req1_ready}, 32'd0);
    exp_we = (a0 && req0_we && !e0_err) || (a1 && req1_we && !e1_err);
    exp_a  = a0 ? req0_addr : (a1 ? req1_addr : 32'd0);
    chk("mem_WE", {31'd0, mem_WE}, {31'd0, exp_we});
    chk("mem_A", mem_A, exp_a);
    gpat = {gpat[8:0], a1};
    if (rst_edge) reset = 1'b1;
    else begin
      if (a0) q0.push_back({e0_err, e0_rd});
      if (a1) q1.push_back({e1_err, e1_rd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(1'b0);
  endtask

  task automatic send(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] erd, input bit eerr);
    bit done = 1'b0;
    if (port == 1'b0) begin
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
      e0_rd = erd; e0_err = eerr;
    end else begin
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
      e1_rd = erd; e1_err = eerr;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      step(1'b0);
      done = port ? a1 : a0;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic both_reads();
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h20; e0_rd = 32'hCAFE0020; e0_err = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h24; e1_rd = 32'h0BAD0024; e1_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b1; req0_addr = 32'h10; req0_wdata = 32'h0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 32'h0;  req1_wdata = 32'h0;
    e0_rd = 32'h0; e0_err = 1'b0; e1_rd = 32'h0; e1_err = 1'b0; gpat = '0;
    step(1'b0);
    req0_valid = 1'b1;
    step(1'b0);
    step(1'b0);
    req0_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("reset_rsp0_rdata", rsp0_rdata, 32'd0);
    chk("reset_rsp1_rdata", rsp1_rdata, 32'd0);
    @(posedge clk); #1;

    // Preload through the arbiter itself
    send(1'b1, 1'b1, 32'h0,  32'h11111111, 32'h0, 1'b0);
    send(1'b1, 1'b1, 32'h4,  32'h22222222, 32'h0, 1'b0);
    send(1'b1, 1'b1, 32'h8,  32'h33333333, 32'h0, 1'b0);
    send(1'b1, 1'b1, 32'h24, 32'h0BAD0024, 32'h0, 1'b0);
    send(1'b0, 1'b1, 32'h20, 32'hCAFE0020, 32'h0, 1'b0);
    idle();

    // Write then read in consecutive cycles
    send(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    send(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    idle();

    // Streaming reads on port 1
    send(1'b1, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0);
    send(1'b1, 1'b0, 32'h4, 32'h0, 32'h22222222, 1'b0);
    send(1'b1, 1'b0, 32'h8, 32'h0, 32'h33333333, 1'b0);
    idle();

    // Misaligned read and out-of-range write; 0x400 would alias word 0 if written
    send(1'b1, 1'b0, 32'h12,  32'h0,         32'h0, 1'b1);
    send(1'b1, 1'b1, 32'h400, 32'hFFFFFFFF,  32'h0, 1'b1);
    send(1'b1, 1'b0, 32'h0,   32'h0, 32'h11111111, 1'b0);
    idle();

    // Contention with MAX_WAIT=4
    both_reads();
    gpat = '0;
    repeat (10) step(1'b0);
    chk("grant_pattern", {22'd0, gpat}, {22'd0, 10'b0000100001});
    idle();

    // Build up wait1, then reset with a port-0 request in flight
    both_reads();
    repeat (2) step(1'b0);
    req0_addr = 32'h10; e0_rd = 32'hDEADBEEF;
    step(1'b1);
    chk("rst_drop_rsp0", {31'd0, rsp0_valid}, 32'd0);
    req0_we = 1'b1; req0_wdata = 32'h5555AAAA;
    step(1'b0);
    reset = 1'b0;
    both_reads();
    gpat = '0;
    repeat (5) step(1'b0);
    chk("grant_after_reset", {22'd0, gpat}, {22'd0, 10'b0000000001});
    idle();
    send(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    idle();
    idle();
    idle();

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
